// File: rtl/hart_pkg.sv
// Shared types and constants for the hart memory stage: funct3 encodings, LSU FSM states,
// byte-mask constants and the registered request record.
package hart_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H_LO = 4'b0011;
    localparam logic [3:0] MASK_H_HI = 4'b1100;
    localparam logic [3:0] MASK_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Fields of an accepted memory op that are still needed after the accept cycle.
    typedef struct packed {
        logic       load;
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
    } lsu_req_t;

endpackage

// File: rtl/hart_lsu_if.sv
// Bundle of the EX/MEM request, data-memory and writeback-response signals around the LSU.
// slave = the LSU's view; master = the pipeline/memory environment's view.
interface hart_lsu_if;

    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_load;
    logic        i_req_store;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [4:0]  i_req_rd;

    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_trap;

    modport slave (
        input  i_req_valid, i_req_load, i_req_store, i_req_funct3, i_req_addr, i_req_wdata, i_req_rd,
        input  i_mem_ready, i_mem_valid, i_mem_rdata,
        output o_req_ready,
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        output o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_rsp_trap
    );

    modport master (
        output i_req_valid, i_req_load, i_req_store, i_req_funct3, i_req_addr, i_req_wdata, i_req_rd,
        output i_mem_ready, i_mem_valid, i_mem_rdata,
        input  o_req_ready,
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_rsp_trap
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, store-data lane shift, load-data shift and extension,
// plus misalignment and illegal-funct3 detection for one access.
module lsu_align
    import hart_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] rsh;

    always_comb begin
        mask_o     = MASK_W;
        misalign_o = 1'b0;
        // funct3[1:0] encodes the access size for both loads and stores.
        unique case (funct3_i[1:0])
            2'b00: mask_o = MASK_B << off_i;
            2'b01: begin
                mask_o     = off_i[1] ? MASK_H_HI : MASK_H_LO;
                misalign_o = off_i[0];
            end
            default: begin
                mask_o     = MASK_W;
                misalign_o = |off_i;
            end
        endcase
    end

    always_comb begin
        if (is_store_i)
            illegal_o = !(funct3_i inside {SB, SH, SW});
        else
            illegal_o = !(funct3_i inside {LB, LH, LW, LBU, LHU});
    end

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign rsh     = rdata_i >> {off_i, 3'b000};

    always_comb begin
        unique case (funct3_i)
            LB:      rdata_o = {{24{rsh[7]}}, rsh[7:0]};
            LH:      rdata_o = {{16{rsh[15]}}, rsh[15:0]};
            LBU:     rdata_o = {24'h0, rsh[7:0]};
            LHU:     rdata_o = {16'h0, rsh[15:0]};
            default: rdata_o = rsh;
        endcase
    end

endmodule

// File: rtl/hart_lsu.sv
// Memory-stage load/store unit: accepts one op at a time, drives a multi-cycle data memory,
// and returns exactly one registered response (data, rd, trap) per accepted op.
module hart_lsu
    import hart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic     i_clk,
    input  logic     i_rst,
    hart_lsu_if.slave bus
);

    localparam int          CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TLIM  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_trap_q, rsp_trap_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;

    logic        idle;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic        al_store;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;
    logic        al_illegal;
    logic        mem_op;
    logic        trap_op;
    logic        to_hit;

    assign idle = (state_q == IDLE);

    // One align instance serves both phases: incoming fields while idle, the held op afterwards.
    assign al_funct3 = idle ? bus.i_req_funct3    : req_q.funct3;
    assign al_off    = idle ? bus.i_req_addr[1:0] : req_q.off;
    assign al_store  = idle ? bus.i_req_store     : ~req_q.load;

    lsu_align u_align (
        .funct3_i   (al_funct3),
        .is_store_i (al_store),
        .off_i      (al_off),
        .wdata_i    (bus.i_req_wdata),
        .rdata_i    (bus.i_mem_rdata),
        .mask_o     (al_mask),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign),
        .illegal_o  (al_illegal)
    );

    assign mem_op  = bus.i_req_load ^ bus.i_req_store;
    assign trap_op = (bus.i_req_load & bus.i_req_store) | (mem_op & (al_misalign | al_illegal));
    assign to_hit  = TO_EN && (cnt_q == CW'(TLIM));

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_trap_d  = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_rd_d    = 5'h0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (trap_op) begin
                        rsp_valid_d = 1'b1;
                        rsp_trap_d  = 1'b1;
                    end else if (!mem_op) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = '{load: bus.i_req_load, funct3: bus.i_req_funct3,
                                    off: bus.i_req_addr[1:0], rd: bus.i_req_rd};
                        addr_d  = {bus.i_req_addr[31:2], 2'b00};
                        mask_d  = al_mask;
                        wdata_d = al_wdata;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                // Completion outranks the timeout so an op finishing on the last cycle is not trapped.
                if (bus.i_mem_ready && (!req_q.load || bus.i_mem_valid)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    if (req_q.load) begin
                        rsp_rdata_d = al_rdata;
                        rsp_rd_d    = req_q.rd;
                    end
                end else if (to_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_trap_d  = 1'b1;
                end else if (bus.i_mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.i_mem_valid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = al_rdata;
                    rsp_rd_d    = req_q.rd;
                end else if (to_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_trap_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_trap_q  <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_trap_q  <= rsp_trap_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    assign bus.o_req_ready = idle;
    assign bus.o_mem_ren   = (state_q == REQ) &  req_q.load;
    assign bus.o_mem_wen   = (state_q == REQ) & ~req_q.load;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_mask  = mask_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_trap  = rsp_trap_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_hart_lsu.sv
// Directed bench for hart_lsu: a vector table for single-op behaviour with an immediate memory,
// plus hand sequences for wait states, timeout and reset during an outstanding load.
module tb_hart_lsu;
    import hart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hart_lsu_if bus ();
    hart_lsu_if bus2 ();

    hart_lsu dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    hart_lsu #(.TIMEOUT_CYCLES(4)) dut_to (.i_clk(clk), .i_rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] mrdata;
        logic        mem;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic        trap;
        logic [31:0] rdata;
        logic [4:0]  rsp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        bus.i_req_valid  = 1'b1;
        bus.i_req_load   = ld;
        bus.i_req_store  = st;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wdata;
        bus.i_req_rd     = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_valid = 0; bus.i_req_load = 0; bus.i_req_store = 0; bus.i_req_funct3 = 0;
        bus.i_req_addr = 0; bus.i_req_wdata = 0; bus.i_req_rd = 0;
        bus.i_mem_ready = 0; bus.i_mem_valid = 0; bus.i_mem_rdata = 0;
        bus2.i_req_valid = 0; bus2.i_req_load = 0; bus2.i_req_store = 0; bus2.i_req_funct3 = 0;
        bus2.i_req_addr = 0; bus2.i_req_wdata = 0; bus2.i_req_rd = 0;
        bus2.i_mem_ready = 0; bus2.i_mem_valid = 0; bus2.i_mem_rdata = 0;

        // ld st f3 addr wdata rd mrdata | mem mask mwdata trap rdata rsp_rd
        vecs.push_back('{1'b0, 1'b1, SB,  32'h1003, 32'h000000AB, 5'd0,  32'h0,        1'b1, 4'b1000, 32'hAB000000, 1'b0, 32'h0,        5'd0});
        vecs.push_back('{1'b1, 1'b0, LH,  32'h2002, 32'h0,        5'd5,  32'h80011234, 1'b1, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 5'd5});
        vecs.push_back('{1'b0, 1'b1, SW,  32'h4000, 32'hDEADBEEF, 5'd0,  32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        5'd0});
        vecs.push_back('{1'b0, 1'b1, SH,  32'h4002, 32'h00001234, 5'd0,  32'h0,        1'b1, 4'b1100, 32'h12340000, 1'b0, 32'h0,        5'd0});
        vecs.push_back('{1'b0, 1'b1, SB,  32'h4001, 32'h123456CD, 5'd0,  32'h0,        1'b1, 4'b0010, 32'h3456CD00, 1'b0, 32'h0,        5'd0});
        vecs.push_back('{1'b1, 1'b0, LW,  32'h3000, 32'h0,        5'd7,  32'h12345678, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h12345678, 5'd7});
        vecs.push_back('{1'b1, 1'b0, LB,  32'h3001, 32'h0,        5'd1,  32'h12348056, 1'b1, 4'b0010, 32'h0,        1'b0, 32'hFFFFFF80, 5'd1});
        vecs.push_back('{1'b1, 1'b0, LB,  32'h3002, 32'h0,        5'd11, 32'h007F0000, 1'b1, 4'b0100, 32'h0,        1'b0, 32'h0000007F, 5'd11});
        vecs.push_back('{1'b1, 1'b0, LBU, 32'h3003, 32'h0,        5'd2,  32'hC0000000, 1'b1, 4'b1000, 32'h0,        1'b0, 32'h000000C0, 5'd2});
        vecs.push_back('{1'b1, 1'b0, LHU, 32'h3000, 32'h0,        5'd3,  32'h0000F00D, 1'b1, 4'b0011, 32'h0,        1'b0, 32'h0000F00D, 5'd3});
        vecs.push_back('{1'b1, 1'b0, LW,  32'h3002, 32'h0,        5'd9,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h3000, 32'h0,     5'd9,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b1, 1'b0, LH,  32'h2003, 32'h0,        5'd9,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b0, 1'b1, SH,  32'h1001, 32'h5555,     5'd0,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h1000, 32'h5555,  5'd0,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b1, 1'b1, LW,  32'h1000, 32'h5555,     5'd9,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        5'd0});
        vecs.push_back('{1'b0, 1'b0, LW,  32'h1000, 32'h0,        5'd4,  32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h0,        5'd0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.o_req_ready, 1);
        chk("rst_ren",       bus.o_mem_ren,   0);
        chk("rst_wen",       bus.o_mem_wen,   0);
        chk("rst_addr",      bus.o_mem_addr,  0);
        chk("rst_mask",      bus.o_mem_mask,  0);
        chk("rst_wdata",     bus.o_mem_wdata, 0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_rsp_trap",  bus.o_rsp_trap,  0);
        chk("rst_rsp_rdata", bus.o_rsp_rdata, 0);
        chk("rst_rsp_rd",    bus.o_rsp_rd,    0);
        rst = 1'b0;
        @(negedge clk);

        // Table: memory always ready with data; each op issued the cycle the previous response shows
        bus.i_mem_ready = 1'b1;
        bus.i_mem_valid = 1'b1;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive_req(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
            bus.i_mem_rdata = v.mrdata;
            chk($sformatf("v%0d_req_ready", i), bus.o_req_ready, 1);
            @(negedge clk);
            bus.i_req_valid = 1'b0;
            if (v.mem) begin
                chk($sformatf("v%0d_ren", i),  bus.o_mem_ren,  v.ld);
                chk($sformatf("v%0d_wen", i),  bus.o_mem_wen,  v.st);
                chk($sformatf("v%0d_addr", i), bus.o_mem_addr, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_mask", i), bus.o_mem_mask, v.mask);
                if (v.st) chk($sformatf("v%0d_wdata", i), bus.o_mem_wdata, v.mwdata);
                chk($sformatf("v%0d_early_rsp", i), bus.o_rsp_valid, 0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_rsp_valid", i), bus.o_rsp_valid, 1);
            chk($sformatf("v%0d_rsp_trap", i),  bus.o_rsp_trap,  v.trap);
            chk($sformatf("v%0d_rsp_rdata", i), bus.o_rsp_rdata, v.rdata);
            chk($sformatf("v%0d_rsp_rd", i),    bus.o_rsp_rd,    v.rsp_rd);
            chk($sformatf("v%0d_idle_ren", i),  bus.o_mem_ren,   0);
            chk($sformatf("v%0d_idle_wen", i),  bus.o_mem_wen,   0);
        end
        @(negedge clk);
        chk("tbl_rsp_pulse_end", bus.o_rsp_valid, 0);

        // lbu with ready at T+1, data at T+4
        bus.i_mem_ready = 1'b0;
        bus.i_mem_valid = 1'b0;
        drive_req(1'b1, 1'b0, LBU, 32'h2001, 32'h0, 5'd12);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("lbu_req_ren", bus.o_mem_ren, 1);
        chk("lbu_mask",    bus.o_mem_mask, 4'b0010);
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        chk("lbu_wait1_ren",   bus.o_mem_ren, 0);
        chk("lbu_wait1_ready", bus.o_req_ready, 0);
        chk("lbu_wait1_rsp",   bus.o_rsp_valid, 0);
        @(negedge clk);
        chk("lbu_wait2_ren", bus.o_mem_ren, 0);
        chk("lbu_wait2_rsp", bus.o_rsp_valid, 0);
        @(negedge clk);
        chk("lbu_wait3_rsp", bus.o_rsp_valid, 0);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 32'h0000F000;
        @(negedge clk);
        bus.i_mem_valid = 1'b0;
        chk("lbu_rsp_valid", bus.o_rsp_valid, 1);
        chk("lbu_rsp_rdata", bus.o_rsp_rdata, 32'h000000F0);
        chk("lbu_rsp_rd",    bus.o_rsp_rd,    12);
        chk("lbu_rsp_trap",  bus.o_rsp_trap,  0);
        @(negedge clk);
        chk("lbu_rsp_pulse", bus.o_rsp_valid, 0);

        // Timeout of 4 with memory never ready
        bus2.i_req_valid  = 1'b1;
        bus2.i_req_load   = 1'b1;
        bus2.i_req_funct3 = LW;
        bus2.i_req_addr   = 32'h5000;
        bus2.i_req_rd     = 5'd6;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus2.i_req_valid = 1'b0;
            chk($sformatf("to_ren_c%0d", k),  bus2.o_mem_ren,   1);
            chk($sformatf("to_addr_c%0d", k), bus2.o_mem_addr,  32'h5000);
            chk($sformatf("to_rsp_c%0d", k),  bus2.o_rsp_valid, 0);
        end
        @(negedge clk);
        chk("to_rsp_valid", bus2.o_rsp_valid, 1);
        chk("to_rsp_trap",  bus2.o_rsp_trap,  1);
        chk("to_rsp_rd",    bus2.o_rsp_rd,    0);
        chk("to_rsp_rdata", bus2.o_rsp_rdata, 0);
        chk("to_ren_off",   bus2.o_mem_ren,   0);
        chk("to_ready",     bus2.o_req_ready, 1);
        bus2.i_mem_valid = 1'b1;
        bus2.i_mem_rdata = 32'h1234;
        @(negedge clk);
        bus2.i_mem_valid = 1'b0;
        chk("to_late_valid", bus2.o_rsp_valid, 0);
        @(negedge clk);
        chk("to_late_valid2", bus2.o_rsp_valid, 0);

        // Reset while a load is waiting for data
        bus.i_mem_ready = 1'b1;
        bus.i_mem_valid = 1'b0;
        drive_req(1'b1, 1'b0, LW, 32'h6000, 32'h0, 5'd8);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("rw_ren", bus.o_mem_ren, 1);
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        chk("rw_wait_ren",   bus.o_mem_ren,   0);
        chk("rw_wait_ready", bus.o_req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_idle_ready", bus.o_req_ready, 1);
        chk("rw_no_rsp",     bus.o_rsp_valid, 0);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.i_mem_valid = 1'b0;
        chk("rw_late_rsp",   bus.o_rsp_valid, 0);
        chk("rw_late_ready", bus.o_req_ready, 1);
        @(negedge clk);
        chk("rw_late_rsp2",  bus.o_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
